oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Sprite OAM DMA engine, a sibling bus master to `cpu_6502` on the shared memory bus. It snoops CPU writes to `$4014` and drives the CPU `halt` input so the core stalls. While the CPU is stalled it copies 256 bytes from CPU page `$XX00–$XXFF` into the PPU through repeated writes to `$2004`. Its `dma_active` output selects between the CPU and DMA bus signals in the top-level bus mux.

## Interface
Parameters:
- `DMA_TRIG_ADDR`, default `16'h4014`: CPU write address that starts a transfer.
- `OAM_DATA_ADDR`, default `16'h2004`: destination address for each byte write.

Ports:
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `cpu_addr`  in  16: CPU bus address, snooped.
- `cpu_data_out`  in  8: CPU write data, snooped.
- `cpu_write_en`  in  1: CPU write strobe, snooped.
- `mem_data_in`  in  8: shared read-data bus.
- `halt`  out  1: stalls `cpu_6502`.
- `dma_active`  out  1: bus-mux select; 1 means DMA signals own the bus.
- `dma_addr`  out  16: DMA bus address.
- `dma_data_out`  out  8: DMA write data.
- `dma_write_en`  out  1: DMA write strobe.
- `dma_read_en`  out  1: DMA read strobe.
- `dma_done`  out  1: one-cycle pulse when a transfer completes.

## Operation
- FSM states: `IDLE`, `HALT_WAIT`, `ALIGN`, `RD`, `WR`, `DONE`.
- Registers:
  - `page` (8 bits): latched from `cpu_data_out` on the trigger.
  - `idx` (8 bits): byte counter.
  - `cyc_par` (1 bit): toggles every clock from reset.
- `IDLE`: if `cpu_write_en && cpu_addr==DMA_TRIG_ADDR`, latch `page`, clear `idx`, go to `HALT_WAIT`.
- `HALT_WAIT`:
  - `halt=1`, `dma_active=0` for one dummy cycle, so the CPU's in-flight store retires.
  - Then go to `ALIGN` or `RD` (see Configuration).
- `ALIGN`: `halt=1`, `dma_active=1`, no strobes. Lasts one cycle, then goes to `RD`.
- `RD`: `dma_addr={page,idx}`, `dma_read_en=1`, then go to `WR`.
- `WR`:
  - `dma_addr=OAM_DATA_ADDR`, `dma_write_en=1`.
  - `dma_data_out=mem_data_in`, a combinational path. The memory contract is that read data is valid in the cycle after `dma_read_en`.
  - If `idx==8'hFF`, go to `DONE`; else `idx<=idx+1` and go to `RD`.
- `DONE`: `halt=0`, `dma_active=0`, `dma_done=1` for one cycle, then go to `IDLE`.
- `halt=1` in every state except `IDLE` and `DONE`. `dma_active=1` in `ALIGN`, `RD`, `WR` only.
- Strobes and `dma_addr`/`dma_data_out` are 0 whenever `dma_active=0`.
- Address arithmetic: `idx` is 8 bits and never carries into `page`. Page `$FF` covers `$FF00–$FFFF`.
- Trigger writes seen outside `IDLE` are ignored. No restart, no re-latch of `page`.
- A trigger write in the `DONE` cycle is also ignored.

## Timing
- Reset (`rst==0` at a rising edge) has priority over everything:
  - State becomes `IDLE`; `page`, `idx`, `cyc_par` become 0.
  - Every output reads 0 in the cycle after reset.
  - Reset mid-transfer aborts the transfer: no further writes, `halt` drops the next cycle, no `dma_done` pulse.
- Trigger at edge T: `halt=1` from T+1, first `dma_read_en` at T+2 (or T+3 with alignment).
- Transfer length: 1 (`HALT_WAIT`) + [1 (`ALIGN`)] + 512 (`RD`/`WR`) cycles, then one `DONE` cycle.
  - That is 513 or 514 cycles of `halt` high before `DONE`.
- Byte k: read at cycle 2k, write at cycle 2k+1, counted from the first `RD`.
- Simultaneous trigger and reset: reset wins and no transfer starts.

## Configuration
- `OAM_DMA_ODD_ALIGN_EN` defined:
  - Leaving `HALT_WAIT`, if `cyc_par==1` the FSM goes through `ALIGN`, giving 514 cycles; if `cyc_par==0` it goes straight to `RD`, giving 513.
  - This models NES get/put alignment.
- Undefined: `ALIGN` is unreachable and every transfer takes exactly 513 `halt` cycles. `cyc_par` may be optimised away.

## Test plan
- Memory `$0200+i = i^8'hA5`; CPU writes `8'h02` to `$4014` -> 256 writes to `$2004` with data `A5,A4,...,5A`; `halt` high for 513 (or 514) cycles; one `dma_done` pulse.
- Trigger with page `8'hFF` -> reads `$FF00..$FFFF`, last read address `$FFFF`, no access to `$0000`.
- Second `$4014` write (`8'h03`) during byte 100 -> ignored; all 256 reads stay in page `$02`.
- `rst` low at byte 37 of a transfer -> next cycle `halt=0`, `dma_active=0`, all strobes 0, no `dma_done`; a fresh trigger afterwards runs a full 256-byte transfer.
- With `OAM_DMA_ODD_ALIGN_EN`: trigger aligned so `cyc_par=1` in `HALT_WAIT` -> 514 `halt` cycles; with `cyc_par=0` -> 513. Without the macro: 513 in both cases.
- Non-trigger writes (`$4015`, `$2004`) and reads of `$4014` -> FSM stays `IDLE`, `halt` stays 0.

Source files
------------

// File: rtl/oam_dma_ctrl_if.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl_if
// Bus bundle between the shared CPU memory bus and the sprite OAM DMA engine.
//   cpu_addr/cpu_data_out/cpu_write_en : CPU bus activity, snooped by the DMA
//   mem_data_in                        : shared read-data bus
//   halt                               : CPU stall request
//   dma_active                         : bus-mux select (1 = DMA owns the bus)
//   dma_addr/dma_data_out              : DMA bus address / write data
//   dma_write_en/dma_read_en           : DMA bus strobes
//   dma_done                           : one-cycle end-of-transfer pulse
// Modports: master = bus/system side, slave = DMA engine side.
// ---------------------------------------------------------------------------
interface oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_write_en;
    logic [7:0]  mem_data_in;
    logic        halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_write_en;
    logic        dma_read_en;
    logic        dma_done;

    modport master (
        output cpu_addr, cpu_data_out, cpu_write_en, mem_data_in,
        input  halt, dma_active, dma_addr, dma_data_out,
               dma_write_en, dma_read_en, dma_done
    );

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_write_en, mem_data_in,
        output halt, dma_active, dma_addr, dma_data_out,
               dma_write_en, dma_read_en, dma_done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// Sprite OAM DMA engine. Snoops CPU writes to DMA_TRIG_ADDR, stalls the CPU
// via halt, then copies the 256 bytes of CPU page {page,00..FF} to
// OAM_DATA_ADDR as alternating read / write bus cycles.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : oam_dma_ctrl_if.slave (CPU snoop inputs, read data, DMA outputs)
//
// Optional feature macro: OAM_DMA_ODD_ALIGN_EN
//   Defined   : an extra ALIGN cycle is inserted after HALT_WAIT when the
//               free-running cycle parity is odd (NES get/put alignment).
//   Undefined : ALIGN is never entered; every transfer halts for 513 cycles.
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic          clk,
    input  logic          rst,
    oam_dma_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        ALIGN     = 3'd2,
        RD        = 3'd3,
        WR        = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  page, page_nxt;
    logic [7:0]  idx, idx_nxt;
    logic        trig;

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic        cyc_par;
`endif

    // Registered outputs, decoded from the state being entered.
    logic        halt_q;
    logic        active_q;
    logic        rd_q;
    logic        wr_q;
    logic        done_q;
    logic [15:0] addr_q;

    assign trig = bus.cpu_write_en && (bus.cpu_addr == DMA_TRIG_ADDR);

    // Next-state / next-register decode.
    always_comb begin
        state_nxt = state;
        page_nxt  = page;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (trig) begin
                    page_nxt  = bus.cpu_data_out;
                    idx_nxt   = 8'h00;
                    state_nxt = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                state_nxt = cyc_par ? ALIGN : RD;
`else
                state_nxt = RD;
`endif
            end
            ALIGN: state_nxt = RD;
            RD:    state_nxt = WR;
            WR: begin
                if (idx == 8'hFF) begin
                    state_nxt = DONE;
                end else begin
                    // 8-bit wrap is intentional: idx never carries into page.
                    idx_nxt   = idx + 8'd1;
                    state_nxt = RD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            halt_q   <= 1'b0;
            active_q <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= 16'h0000;
`ifdef OAM_DMA_ODD_ALIGN_EN
            cyc_par  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            page     <= page_nxt;
            idx      <= idx_nxt;
`ifdef OAM_DMA_ODD_ALIGN_EN
            cyc_par  <= ~cyc_par;
`endif
            halt_q   <= (state_nxt == HALT_WAIT) || (state_nxt == ALIGN) ||
                        (state_nxt == RD)        || (state_nxt == WR);
            active_q <= (state_nxt == ALIGN) || (state_nxt == RD) ||
                        (state_nxt == WR);
            rd_q     <= (state_nxt == RD);
            wr_q     <= (state_nxt == WR);
            done_q   <= (state_nxt == DONE);
            // Address is zero outside RD/WR so the mux never sees stale values.
            if (state_nxt == RD)
                addr_q <= {page_nxt, idx_nxt};
            else if (state_nxt == WR)
                addr_q <= OAM_DATA_ADDR;
            else
                addr_q <= 16'h0000;
        end
    end

    assign bus.halt         = halt_q;
    assign bus.dma_active   = active_q;
    assign bus.dma_read_en  = rd_q;
    assign bus.dma_write_en = wr_q;
    assign bus.dma_done     = done_q;
    assign bus.dma_addr     = addr_q;
    // Memory returns read data the cycle after dma_read_en, which is the WR
    // cycle, so the byte is forwarded combinationally.
    assign bus.dma_data_out = wr_q ? bus.mem_data_in : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_ODD_ALIGN_EN
    localparam int ALIGN_EN = 1;
`else
    localparam int ALIGN_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    oam_dma_ctrl_if bus ();

    oam_dma_ctrl #(
        .DMA_TRIG_ADDR(16'h4014),
        .OAM_DATA_ADDR(16'h2004)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Memory: byte at address a is a[7:0]^a[15:8]^A7, so page $02 holds i^A5.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA7;
    endfunction

    logic [7:0] rdata = 8'h00;
    always @(posedge clk) if (bus.dma_read_en) rdata <= mem_byte(bus.dma_addr);
    assign bus.mem_data_in = rdata;

    // Free-running parity model and cycle counter.
    logic tb_par = 1'b0;
    int   cyc = 0;
    always @(posedge clk) begin
        tb_par <= !rst ? 1'b0 : ~tb_par;
        cyc    <= cyc + 1;
    end

    // Bus monitor, sampled on the falling edge.
    logic [7:0]  exp_page = 8'h00;
    int          halt_cnt, done_cnt, rd_cnt, wr_cnt, addr_err, data_err, leak_cnt, zero_cnt;
    int          first_rd_cyc;
    logic [15:0] last_rd;
    logic        prev_rd = 1'b0;

    always @(negedge clk) begin
        if (bus.halt) halt_cnt++;
        if (bus.dma_done) done_cnt++;
        if (!bus.dma_active && (bus.dma_read_en || bus.dma_write_en ||
            bus.dma_addr != 16'h0 || bus.dma_data_out != 8'h0)) leak_cnt++;
        if (bus.dma_read_en) begin
            if (bus.dma_addr !== {exp_page, rd_cnt[7:0]}) addr_err++;
            if (bus.dma_addr == 16'h0000) zero_cnt++;
            if (rd_cnt == 0) first_rd_cyc = cyc;
            last_rd = bus.dma_addr;
            rd_cnt++;
        end
        if (bus.dma_write_en) begin
            if (!prev_rd || bus.dma_addr !== 16'h2004 ||
                bus.dma_data_out !== mem_byte({exp_page, wr_cnt[7:0]})) data_err++;
            wr_cnt++;
        end
        prev_rd = bus.dma_read_en;
    end

    task automatic clr_mon();
        halt_cnt = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        addr_err = 0; data_err = 0; leak_cnt = 0; zero_cnt = 0;
        first_rd_cyc = -1; last_rd = 16'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU write cycle. want_par: 0/1 forces cyc_par seen in the cycle
    // after the write edge, 2 = don't care.
    int   trig_cyc;
    logic par_hw;
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int want_par);
        @(negedge clk);
        if (want_par != 2) begin
            int guard = 0;
            while (tb_par != !want_par[0] && guard < 4) begin
                @(negedge clk);
                guard++;
            end
        end
        #1;
        bus.cpu_addr = a; bus.cpu_data_out = d; bus.cpu_write_en = 1'b1;
        @(posedge clk); #1;
        trig_cyc = cyc; par_hw = tb_par;
        bus.cpu_write_en = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_data_out = 8'h0;
    endtask

    task automatic wait_done(input string tag);
        int   n = 0;
        logic seen = 1'b0;
        while (n < 1200 && !seen) begin
            @(negedge clk); #1;
            seen = bus.dma_done;
            n++;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_halt_in_done"}, bus.halt, 1'b0);
    endtask

    // Full transfer with all end-of-transfer checks.
    task automatic run_xfer(input string tag, input logic [7:0] pg, input int want_par);
        int exp_halt;
        clr_mon();
        exp_page = pg;
        cpu_write(16'h4014, pg, want_par);
        exp_halt = 513 + ((ALIGN_EN != 0 && par_hw) ? 1 : 0);
        @(negedge clk); #1;
        check({tag, "_hw_halt"}, bus.halt, 1'b1);
        check({tag, "_hw_active"}, bus.dma_active, 1'b0);
        wait_done(tag);
        check({tag, "_halt_cycles"}, halt_cnt, exp_halt);
        check({tag, "_first_rd_lat"}, first_rd_cyc - trig_cyc, exp_halt - 512);
        check({tag, "_reads"}, rd_cnt, 256);
        check({tag, "_writes"}, wr_cnt, 256);
        check({tag, "_addr_err"}, addr_err, 0);
        check({tag, "_data_err"}, data_err, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_leak"}, leak_cnt, 0);
    endtask

    initial begin
        bus.cpu_addr = 16'h0; bus.cpu_data_out = 8'h0; bus.cpu_write_en = 1'b0;
        clr_mon();

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_halt", bus.halt, 1'b0);
        check("rst_active", bus.dma_active, 1'b0);
        check("rst_addr", bus.dma_addr, 16'h0);
        check("rst_data", bus.dma_data_out, 8'h0);
        check("rst_strobes", {bus.dma_read_en, bus.dma_write_en, bus.dma_done}, 3'b000);
        @(negedge clk); rst = 1'b1;

        // Non-trigger bus traffic
        clr_mon();
        cpu_write(16'h4015, 8'h02, 2);
        cpu_write(16'h2004, 8'h02, 2);
        @(negedge clk); #1;
        bus.cpu_addr = 16'h4014; bus.cpu_data_out = 8'h02;   // read: no write strobe
        repeat (2) @(negedge clk);
        bus.cpu_addr = 16'h0; bus.cpu_data_out = 8'h0;
        repeat (3) @(negedge clk);
        check("nontrig_halt", halt_cnt, 0);
        check("nontrig_reads", rd_cnt, 0);

        // Page $02, both parities
        run_xfer("p02_par0", 8'h02, 0);
        // Trigger landing in the DONE cycle must be ignored.
        bus.cpu_addr = 16'h4014; bus.cpu_data_out = 8'h05; bus.cpu_write_en = 1'b1;
        @(posedge clk); #1;
        bus.cpu_write_en = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_data_out = 8'h0;
        clr_mon();
        repeat (5) @(negedge clk);
        check("done_trig_halt", halt_cnt, 0);
        check("done_trig_reads", rd_cnt, 0);

        run_xfer("p02_par1", 8'h02, 1);

        // Page $FF: no wrap into $0000
        run_xfer("pFF", 8'hFF, 2);
        check("pFF_last_rd", last_rd, 16'hFFFF);
        check("pFF_zero_acc", zero_cnt, 0);

        // Re-trigger during byte 100 is ignored
        begin
            int n = 0;
            clr_mon();
            exp_page = 8'h02;
            cpu_write(16'h4014, 8'h02, 2);
            while (wr_cnt < 100 && n < 1000) begin @(negedge clk); #1; n++; end
            check("retrig_reach100", wr_cnt, 100);
            bus.cpu_addr = 16'h4014; bus.cpu_data_out = 8'h03; bus.cpu_write_en = 1'b1;
            @(posedge clk); #1;
            bus.cpu_write_en = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_data_out = 8'h0;
            wait_done("retrig");
            check("retrig_reads", rd_cnt, 256);
            check("retrig_addr_err", addr_err, 0);
            check("retrig_data_err", data_err, 0);
            check("retrig_done_cnt", done_cnt, 1);
            repeat (4) @(negedge clk);
            check("retrig_no_restart", rd_cnt, 256);
        end

        // Reset at byte 37 aborts cleanly
        begin
            int n = 0;
            clr_mon();
            exp_page = 8'h02;
            cpu_write(16'h4014, 8'h02, 2);
            while (wr_cnt < 37 && n < 1000) begin @(negedge clk); #1; n++; end
            check("abort_reach37", wr_cnt, 37);
            rst = 1'b0;
            @(posedge clk); #1;
            check("abort_halt", bus.halt, 1'b0);
            check("abort_active", bus.dma_active, 1'b0);
            check("abort_strobes", {bus.dma_read_en, bus.dma_write_en, bus.dma_done}, 3'b000);
            check("abort_addr", bus.dma_addr, 16'h0);
            @(negedge clk); rst = 1'b1;
            repeat (6) @(negedge clk);
            check("abort_writes", wr_cnt, 37);
            check("abort_no_done", done_cnt, 0);
        end
        run_xfer("after_abort", 8'h02, 2);

        // Simultaneous trigger and reset: reset wins
        clr_mon();
        @(negedge clk); #1;
        rst = 1'b0;
        bus.cpu_addr = 16'h4014; bus.cpu_data_out = 8'h02; bus.cpu_write_en = 1'b1;
        @(posedge clk); #1;
        bus.cpu_write_en = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_data_out = 8'h0;
        @(negedge clk); rst = 1'b1;
        repeat (6) @(negedge clk);
        check("rsttrig_halt", halt_cnt, 0);
        check("rsttrig_reads", rd_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
